pipe_ctrl: RTL

Parametrised pipeline control unit replacing the fixed single-source stall controller of the 5-stage core. Merges per-stage stall requests (load-use from ID, memory wait, etc.) into a hold/bubble vector. Tracks multi-cycle EX operations (mul/div) through a start/done handshake. Issues whole-pipe flush plus PC redirect on exception or eret. Sits beside IF/ID/EX/MEM/WB in mycpu_core; its stall output drives every stage's pipeline register.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pctrl_stall_encode.sv | 19 +
 rtl/pipe_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared state encodings and stage index constants for the pipeline control unit.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        PCTRL_IDLE    = 2'd0,
        PCTRL_MC_BUSY = 2'd1,
        PCTRL_FLUSH   = 2'd2
    } pctrl_state_t;

    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MC  = 3;
    localparam int unsigned STG_MEM = 4;
    localparam int unsigned STG_WB  = 5;

endpackage

// File: rtl/pctrl_stall_encode.sv
// Converts an effective stall request index into a thermometer hold vector:
// registers 0..req_idx hold, register req_idx+1 receives a bubble.
module pctrl_stall_encode #(
    parameter int unsigned NUM_STAGES = 6,
    parameter int unsigned IDX_W      = $clog2(NUM_STAGES)
) (
    input  logic                  req_valid,
    input  logic [IDX_W-1:0]      req_idx,
    output logic [NUM_STAGES-1:0] stall
);

    always_comb begin
        stall = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            stall[i] = req_valid && (i <= 32'(req_idx));
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stage stall requests, tracks multi-cycle EX ops and
// issues flush/redirect on exceptions. Optional perf counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 6,
    parameter int unsigned MC_STAGE   = 3,
    parameter int unsigned PC_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stallreq,
    input  logic                  mc_start,
    input  logic                  mc_done,
    output logic                  mc_cancel,
    output logic                  mc_busy,
    input  logic                  excp_valid,
    input  logic [PC_W-1:0]       excp_pc,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  redirect_valid,
    output logic [PC_W-1:0]       redirect_pc
`ifdef PIPE_CTRL_PERF_EN
   ,output logic [31:0]           perf_stall_cyc,
    output logic [31:0]           perf_mc_cyc,
    output logic [31:0]           perf_flush_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_STAGES);

    pctrl_state_t     state, state_nx;
    logic             req_valid;
    logic [IDX_W-1:0] req_idx;
    logic             mc_req;

    always_ff @(posedge clk) begin
        if (rst) state <= PCTRL_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        req_valid      = 1'b0;
        req_idx        = '0;
        mc_req         = 1'b0;
        flush          = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mc_cancel      = 1'b0;
        if (rst) begin
            state_nx = PCTRL_IDLE;
        end else if (excp_valid) begin
            state_nx       = PCTRL_FLUSH;
            flush          = {{(NUM_STAGES-1){1'b1}}, 1'b0};
            redirect_valid = 1'b1;
            redirect_pc    = excp_pc;
            mc_cancel      = (state == PCTRL_MC_BUSY) || mc_start;
        end else begin
            case (state)
                PCTRL_IDLE: begin
                    // the issuing cycle already holds MC_STAGE
                    if (mc_start) begin
                        state_nx = PCTRL_MC_BUSY;
                        mc_req   = 1'b1;
                    end
                end
                PCTRL_MC_BUSY: begin
                    if (mc_done) state_nx = PCTRL_IDLE;
                    else         mc_req   = 1'b1;
                end
                PCTRL_FLUSH: state_nx = PCTRL_IDLE;
                default:     state_nx = PCTRL_IDLE;
            endcase
            if (state != PCTRL_FLUSH) begin
                for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                    if (i != 0 && stallreq[i]) begin
                        req_valid = 1'b1;
                        req_idx   = IDX_W'(i);
                    end
                end
                if (mc_req && (!req_valid || 32'(req_idx) < MC_STAGE)) begin
                    req_idx = IDX_W'(MC_STAGE);
                end
                req_valid = req_valid || mc_req;
            end
        end
    end

    assign mc_busy = !rst && (state == PCTRL_MC_BUSY);

    pctrl_stall_encode #(
        .NUM_STAGES (NUM_STAGES),
        .IDX_W      (IDX_W)
    ) u_stall_encode (
        .req_valid (req_valid),
        .req_idx   (req_idx),
        .stall     (stall)
    );

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cyc <= '0;
            perf_mc_cyc    <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall[0])                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (state == PCTRL_MC_BUSY)  perf_mc_cyc    <= perf_mc_cyc + 32'd1;
            if (excp_valid)              perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
